sequential_fixed_multiplier: RTL and testbench
==============================================

# sequential_fixed_multiplier

Multi-cycle shift-add multiplier: takes a Q(ARG_BIT_WIDTH).(PRECISION) fixed-point quotient, as produced by the divider, and an ARG_BIT_WIDTH-bit unsigned integer divisor. It returns their product plus a rounded integer. It is the reverse of the divider path and reconstructs the dividend A ≈ Q·B. It sits beside the divider for self-check and for scaling fixed-point results back to integers.

## Interface
- ARG_BIT_WIDTH, 32: integer operand width; integer-part width of Q.
- PRECISION, 64: fraction bits of Q.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- Q  in  ARG_BIT_WIDTH+PRECISION  unsigned fixed-point multiplicand; bits [PRECISION-1:0] are the fraction.
- B  in  ARG_BIT_WIDTH  unsigned integer multiplier.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when the result is valid.
- P  out  2·ARG_BIT_WIDTH+PRECISION  full product, fraction in [PRECISION-1:0].
- A_rec  out  ARG_BIT_WIDTH  integer part of P, rounded half-up, saturated.
- OVF  out  1  integer part of P ≥ 2^ARG_BIT_WIDTH, or the rounding carry overflowed.

## Operation
- Clocking and reset: one clock; reset is asynchronous and active-low.
- States:
  - IDLE: start=1 latches Q and B into internal registers, clears the accumulator and step counter, then goes to RUN.
  - RUN: each cycle, if the current LSB of the B register is 1, add Q shifted left by the step index to the accumulator. Then shift the B register right and increment the counter. When the counter reaches ARG_BIT_WIDTH-1, go to DONE.
  - DONE: P, A_rec and OVF register from the accumulator; done=1 for exactly this cycle; go to IDLE.
- Width: the accumulator is 2·ARG_BIT_WIDTH+PRECISION bits, so the product is exact with no truncation.
- Rounding: A_rec = P[PRECISION+ARG_BIT_WIDTH-1:PRECISION] + P[PRECISION-1].
- Saturation: if OVF, A_rec = all ones.
- Operands are captured at start, so Q and B may change during RUN without effect.
- start during RUN or DONE is ignored; it is not queued.
- B=0 still takes the full latency and gives P=0, A_rec=0, OVF=0.
- P, A_rec and OVF hold their values from DONE until the next DONE.

## Timing
- Reset values: busy=0, done=0, P=0, A_rec=0, OVF=0, state IDLE.
- Assertion of rst_n=0 mid-RUN aborts immediately; no done pulse follows.
- start sampled high at edge t:
  - busy=1 from t through t+ARG_BIT_WIDTH.
  - done=1 and outputs update after edge t+ARG_BIT_WIDTH+1.
  - Latency is ARG_BIT_WIDTH+1 cycles.
- A new start is accepted at the edge following the done cycle at the earliest.
- Back-to-back throughput: one result per ARG_BIT_WIDTH+2 cycles.

## Structure
- The shared package divider_pkg holds:
  - ARG_BIT_WIDTH and PRECISION, which the divider and reciprocal also import;
  - the state enum {IDLE, RUN, DONE};
  - derived widths QW = ARG_BIT_WIDTH+PRECISION and PW = 2·ARG_BIT_WIDTH+PRECISION.
- Single module with no sub-module. The shift-add datapath is small and fits alongside the FSM. Rounding and saturation are combinational logic feeding the DONE-state output registers.

## Test plan
- Q=3<<64 (3.0), B=5, start one cycle:
  - busy for 33 cycles;
  - done pulse 33 cycles after the start edge;
  - P=15<<64, A_rec=15, OVF=0.
- Q=0x0_5555555555555555 (1/3 truncated), B=3:
  - P integer part 0, fraction 0xFFFFFFFFFFFFFFFF;
  - A_rec=1 (rounded up), OVF=0.
- Q=all ones, B=0xFFFFFFFF:
  - P equals the exact 128-bit product;
  - OVF=1, A_rec=0xFFFFFFFF.
- Capture and repeat-start checks:
  - start with Q=2.5, B=4; change Q/B and pulse start again at cycle 10 of RUN;
  - result is A_rec=10, there is exactly one done pulse, and the second start is ignored.
- Reset mid-operation:
  - rst_n low at cycle 12 of RUN;
  - busy, done and outputs are 0 immediately, with no later done;
  - a new start after release completes normally.
- Back-to-back requests:
  - start held high continuously;
  - done pulses every 34 cycles;
  - the first result stays stable until the second done.

Source files
------------

// File: rtl/divider_pkg.sv
// Widths and FSM states shared by the divider, reciprocal and multiplier.
package divider_pkg;
  localparam int ARG_BIT_WIDTH = 32;
  localparam int PRECISION     = 64;
  localparam int QW            = ARG_BIT_WIDTH + PRECISION;
  localparam int PW            = 2 * ARG_BIT_WIDTH + PRECISION;
  localparam int STEP_W        = $clog2(ARG_BIT_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;
endpackage

// File: rtl/sequential_fixed_multiplier_if.sv
// Request/result bundle of the fixed-point shift-add multiplier.
interface sequential_fixed_multiplier_if;
  import divider_pkg::*;

  logic                     start;
  logic [QW-1:0]            Q;
  logic [ARG_BIT_WIDTH-1:0] B;
  logic                     busy;
  logic                     done;
  logic [PW-1:0]            P;
  logic [ARG_BIT_WIDTH-1:0] A_rec;
  logic                     OVF;

  modport master (
    output start, Q, B,
    input  busy, done, P, A_rec, OVF
  );

  modport slave (
    input  start, Q, B,
    output busy, done, P, A_rec, OVF
  );
endinterface

// File: rtl/sequential_fixed_multiplier.sv
// Multi-cycle shift-add multiplier: Q(fixed point) * B(integer) -> exact product
// plus a rounded, saturated integer reconstruction of the dividend.
module sequential_fixed_multiplier
  import divider_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  sequential_fixed_multiplier_if.slave bus
);

  localparam int W = ARG_BIT_WIDTH;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(W - 1);

  state_t            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [W-1:0]      b_q, b_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     p_q, p_d;
  logic [W-1:0]      a_rec_q, a_rec_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              busy;

  logic [W:0]        rnd_sum;
  logic              rnd_ovf;
  logic [W-1:0]      rnd_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (step_q == LAST_STEP) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // busy covers the result-registering cycle too, so it spans the whole latency.
  always_comb begin
    busy = (state_q != IDLE);
  end

  // Half-up rounding on the first fraction bit; any set bit above the integer
  // width, or a carry out of the rounding add, saturates the result.
  always_comb begin
    rnd_sum = {1'b0, acc_q[PRECISION+W-1:PRECISION]} + {{W{1'b0}}, acc_q[PRECISION-1]};
    rnd_ovf = (|acc_q[PW-1:PRECISION+W]) | rnd_sum[W];
    rnd_val = rnd_ovf ? {W{1'b1}} : rnd_sum[W-1:0];
  end

  always_comb begin
    step_d  = step_q;
    b_d     = b_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    p_d     = p_q;
    a_rec_d = a_rec_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d = PW'(bus.Q);
          b_d     = bus.B;
          acc_d   = '0;
          step_d  = '0;
        end
      end
      RUN: begin
        // The multiplicand register shifts left in step with B, so it always
        // holds Q << step without a barrel shifter.
        if (b_q[0]) acc_d = acc_q + mcand_q;
        mcand_d = mcand_q << 1;
        b_d     = b_q >> 1;
        step_d  = step_q + 1'b1;
      end
      DONE: begin
        p_d     = acc_q;
        a_rec_d = rnd_val;
        ovf_d   = rnd_ovf;
        done_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q  <= '0;
      b_q     <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      a_rec_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      step_q  <= step_d;
      b_q     <= b_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      a_rec_q <= a_rec_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy  = busy;
  assign bus.done  = done_q;
  assign bus.P     = p_q;
  assign bus.A_rec = a_rec_q;
  assign bus.OVF   = ovf_q;

endmodule

// File: tb/tb_sequential_fixed_multiplier.sv
// Randomised and directed checks of the sequential fixed-point multiplier
// against a plain-arithmetic reference model.
module tb_sequential_fixed_multiplier;
  import divider_pkg::*;

  localparam int W = ARG_BIT_WIDTH;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sequential_fixed_multiplier_if bus();

  sequential_fixed_multiplier dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer product, integer part rounded on the half bit.
  task automatic model(input logic [QW-1:0] q, input logic [W-1:0] b,
                       output logic [PW-1:0] p, output logic [W-1:0] a, output logic ovf);
    logic [PW-1:0] ip;
    p   = PW'(q) * PW'(b);
    ip  = (p >> PRECISION) + PW'(p[PRECISION-1]);
    ovf = (ip >= (PW'(1) << W));
    a   = ovf ? {W{1'b1}} : ip[W-1:0];
  endtask

  function automatic logic [QW-1:0] rand_q();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return QW'(r);
  endfunction

  task automatic run_op(input string name, input logic [QW-1:0] q, input logic [W-1:0] b,
                        input int disturb_k, input int abort_k);
    logic [PW-1:0] exp_p;
    logic [W-1:0]  exp_a;
    logic          exp_ovf;
    int busy_cnt, done_cnt, done_k, kmax;
    model(q, b, exp_p, exp_a, exp_ovf);
    busy_cnt = 0;
    done_cnt = 0;
    done_k   = -1;
    kmax     = (disturb_k >= 0 || abort_k >= 0) ? W + 41 : W + 2;
    @(negedge clk);
    bus.start = 1'b1;
    bus.Q     = q;
    bus.B     = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.Q     = rand_q();
    bus.B     = $urandom();
    for (int k = 0; k <= kmax; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_k < 0) begin
          done_k = k;
          check({name, "_P"}, bus.P, exp_p);
          check({name, "_A_rec"}, PW'(bus.A_rec), PW'(exp_a));
          check({name, "_OVF"}, PW'(bus.OVF), PW'(exp_ovf));
        end
      end
      if (disturb_k >= 0 && k == disturb_k) begin
        bus.start = 1'b1;
        bus.Q     = rand_q();
        bus.B     = $urandom();
      end else if (disturb_k >= 0 && k == disturb_k + 1) begin
        bus.start = 1'b0;
      end
      if (abort_k >= 0 && k == abort_k) begin
        rst_n = 1'b0;
        #1;
        check({name, "_abort_busy"}, PW'(bus.busy), '0);
        check({name, "_abort_done"}, PW'(bus.done), '0);
        check({name, "_abort_P"}, bus.P, '0);
        check({name, "_abort_A_rec"}, PW'(bus.A_rec), '0);
        check({name, "_abort_OVF"}, PW'(bus.OVF), '0);
      end else if (abort_k >= 0 && k == abort_k + 2) begin
        rst_n = 1'b1;
      end
    end
    if (abort_k >= 0) begin
      check({name, "_abort_done_cnt"}, PW'(done_cnt), '0);
    end else begin
      check({name, "_busy_cycles"}, PW'(busy_cnt), PW'(W + 1));
      check({name, "_latency"}, PW'(done_k), PW'(W + 1));
      check({name, "_done_cnt"}, PW'(done_cnt), PW'(1));
    end
    $display("op %s Q=0x%0h B=0x%0h P=0x%0h A_rec=0x%0h OVF=%0d", name, q, b, bus.P, bus.A_rec, bus.OVF);
  endtask

  task automatic run_b2b(input logic [QW-1:0] q1, input logic [W-1:0] b1,
                         input logic [QW-1:0] q2, input logic [W-1:0] b2);
    logic [PW-1:0] p1, p2;
    logic [W-1:0]  a1, a2;
    logic          o1, o2;
    int done_cnt, k1, k2;
    model(q1, b1, p1, a1, o1);
    model(q2, b2, p2, a2, o2);
    done_cnt = 0;
    k1 = -1;
    k2 = -1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.Q     = q1;
    bus.B     = b1;
    @(posedge clk);
    @(negedge clk);
    bus.Q = q2;
    bus.B = b2;
    for (int k = 0; k <= 2 * W + 8; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.done) begin
        done_cnt++;
        if (k1 < 0) begin
          k1 = k;
          check("b2b_first_P", bus.P, p1);
          check("b2b_first_A_rec", PW'(bus.A_rec), PW'(a1));
        end else if (k2 < 0) begin
          k2 = k;
          check("b2b_second_P", bus.P, p2);
          check("b2b_second_A_rec", PW'(bus.A_rec), PW'(a2));
          check("b2b_second_OVF", PW'(bus.OVF), PW'(o2));
        end
      end else if (k1 >= 0 && k2 < 0) begin
        check("b2b_hold_P", bus.P, p1);
      end
      if (k == W + 6) bus.start = 1'b0;
    end
    check("b2b_done_cnt", PW'(done_cnt), PW'(2));
    check("b2b_first_k", PW'(k1), PW'(W + 1));
    check("b2b_second_k", PW'(k2), PW'(2 * W + 3));
    $display("op b2b first_done=%0d second_done=%0d", k1, k2);
  endtask

  initial begin
    logic [QW-1:0] q;
    logic [W-1:0]  b;
    int            mode;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.Q     = '0;
    bus.B     = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", PW'(bus.busy), '0);
    check("reset_done", PW'(bus.done), '0);
    check("reset_P", bus.P, '0);
    check("reset_A_rec", PW'(bus.A_rec), '0);
    check("reset_OVF", PW'(bus.OVF), '0);
    rst_n = 1'b1;

    q = QW'(3) << PRECISION;
    run_op("three_x5", q, W'(5), -1, -1);
    check("three_x5_P_const", bus.P, PW'(15) << PRECISION);
    check("three_x5_A_rec_const", PW'(bus.A_rec), PW'(15));

    q = QW'(64'h5555_5555_5555_5555);
    run_op("third_x3", q, W'(3), -1, -1);
    check("third_x3_A_rec_const", PW'(bus.A_rec), PW'(1));
    check("third_x3_frac_const", bus.P, PW'(64'hFFFF_FFFF_FFFF_FFFF));

    q = '1;
    run_op("max_x_max", q, '1, -1, -1);
    check("max_x_max_OVF_const", PW'(bus.OVF), PW'(1));
    check("max_x_max_A_rec_const", PW'(bus.A_rec), PW'(32'hFFFF_FFFF));

    run_op("b_zero", rand_q(), '0, -1, -1);
    check("b_zero_P_const", bus.P, '0);

    q = (QW'(2) << PRECISION) | (QW'(1) << (PRECISION - 1));
    run_op("capture", q, W'(4), 10, -1);
    check("capture_A_rec_const", PW'(bus.A_rec), PW'(10));

    run_op("abort", rand_q(), $urandom(), -1, 12);
    run_op("after_abort", rand_q(), $urandom(), -1, -1);

    run_b2b(rand_q(), $urandom(), QW'(7) << PRECISION, W'(6));

    for (int i = 0; i < 20; i++) begin
      mode = i % 3;
      q = rand_q();
      b = $urandom();
      if (mode == 1) begin
        q[QW-1:PRECISION] = W'($urandom_range(0, 15));
        b = W'($urandom_range(0, 32'h0FFF_FFFF));
      end else if (mode == 2) begin
        b = (i % 2 == 0) ? W'(1) : '1;
      end
      run_op($sformatf("rand%0d", i), q, b, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
